// File: rtl/decode_imm_stage_pkg.sv
// Shared format codes and RV opcode constants for the decode/immediate stage.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;

endpackage

// File: rtl/decode_imm_stage_if.sv
// Input/output handshake bundle of decode_imm_stage; slave is the stage's view.
interface decode_imm_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_imm_stage_imm_decode.sv
// Combinational format/immediate decoder from the opcode field.
// Optional IMM_ZICSR_EN: CSR-immediate SYSTEM ops decode as FMT_Z with uimm.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] raw;

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    unique case (instr[6:0])
      OP_LUI, OP_AUIPC:                     fmt = FMT_U;
      OP_JAL:                               fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM:           fmt = FMT_I;
`ifdef IMM_ZICSR_EN
      OP_SYSTEM:                            fmt = instr[14] ? FMT_Z : FMT_I;
`else
      OP_SYSTEM:                            fmt = FMT_I;
`endif
      OP_STORE:                             fmt = FMT_S;
      OP_BRANCH:                            fmt = FMT_B;
      OP_OP:                                fmt = FMT_R;
      OP_OPIMM32:                           if (XLEN == 64) fmt = FMT_I; else illegal = 1'b1;
      OP_OP32:                              if (XLEN == 64) fmt = FMT_R; else illegal = 1'b1;
      default:                              illegal = 1'b1;
    endcase
  end

  // raw is the 32-bit signed immediate; widening below replicates bit 31.
  always_comb begin
    raw = '0;
    if (!illegal) begin
      unique case (fmt)
        FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
        FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        FMT_U:   raw = {instr[31:12], 12'b0};
        FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        FMT_Z:   raw = {27'b0, instr[19:15]};
        default: raw = '0;
      endcase
    end
    imm = XLEN'(signed'(raw));
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode-at-enqueue stage: decodes format/immediate and buffers in a DEPTH-entry FIFO.
// Optional IMM_ZICSR_EN (see imm_decode) enables the FMT_Z CSR-immediate format.
module decode_imm_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  decode_imm_stage_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fmt_e             dec_fmt;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic             full;
  logic             push;
  logic             pop;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instr   (bus.in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // rst gates the handshakes so outputs are quiet during the cycle reset is first seen.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign bus.in_ready  = !full && !rst;
  assign bus.out_valid = (count_q != '0) && !rst;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_entry.instr   = bus.in_instr;
    wr_entry.pc      = bus.in_pc;
    wr_entry.fmt     = dec_fmt;
    wr_entry.imm     = dec_imm;
    wr_entry.illegal = dec_illegal;
  end

  assign rd_entry        = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_instr   = rd_entry.instr;
  assign bus.out_pc      = rd_entry.pc;
  assign bus.out_fmt     = rd_entry.fmt;
  assign bus.out_imm     = rd_entry.imm;
  assign bus.out_illegal = rd_entry.illegal;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_decode_imm_stage.sv
// Scoreboard bench for decode_imm_stage: XLEN=32/DEPTH=2 and XLEN=64/DEPTH=4 instances.
module tb_decode_imm_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst64;

  decode_imm_stage_if #(.XLEN(32)) if32 ();
  decode_imm_stage_if #(.XLEN(64)) if64 ();

  decode_imm_stage #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst(rst32), .bus(if32));
  decode_imm_stage #(.XLEN(64), .DEPTH(4)) dut64 (.clk(clk), .rst(rst64), .bus(if64));

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  fmt32;
    logic [31:0] imm32;
    logic        ill32;
    logic [2:0]  fmt64;
    logic [63:0] imm64;
    logic        ill64;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

`ifdef IMM_ZICSR_EN
  localparam logic [2:0]  CSR_FMT = 3'd6;
  localparam logic [31:0] CSR_IMM = 32'h0000001F;
`else
  localparam logic [2:0]  CSR_FMT = 3'd1;
  localparam logic [31:0] CSR_IMM = 32'h00000300;
`endif

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  exp_t q32 [$];
  exp_t q64 [$];
  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic push32(input int i, input logic [31:0] pc);
    exp_t e;
    logic ok;
    e.instr = vecs[i].instr; e.pc = {32'h0, pc}; e.fmt = vecs[i].fmt32;
    e.imm = {32'h0, vecs[i].imm32}; e.illegal = vecs[i].ill32;
    if32.in_valid = 1'b1; if32.in_instr = vecs[i].instr; if32.in_pc = pc;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if32.in_ready) begin q32.push_back(e); ok = 1'b1; end
      @(posedge clk); #1;
    end
    if32.in_valid = 1'b0;
    check("push32_accept", ok, 1'b1);
  endtask

  task automatic push64(input int i, input logic [63:0] pc);
    exp_t e;
    logic ok;
    e.instr = vecs[i].instr; e.pc = pc; e.fmt = vecs[i].fmt64;
    e.imm = vecs[i].imm64; e.illegal = vecs[i].ill64;
    if64.in_valid = 1'b1; if64.in_instr = vecs[i].instr; if64.in_pc = pc;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if64.in_ready) begin q64.push_back(e); ok = 1'b1; end
      @(posedge clk); #1;
    end
    if64.in_valid = 1'b0;
    check("push64_accept", ok, 1'b1);
  endtask

  task automatic drain32();
    for (int c = 0; c < 60 && q32.size() != 0; c++) @(posedge clk);
    #1;
    check("drain32_empty", q32.size(), 0);
  endtask

  task automatic drain64();
    for (int c = 0; c < 60 && q64.size() != 0; c++) @(posedge clk);
    #1;
    check("drain64_empty", q64.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT completes an output transfer.
  initial begin
    exp_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      if (if32.out_valid && if32.out_ready) begin
        check("out32_expected", q32.size() != 0, 1'b1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          a.instr = if32.out_instr; a.pc = {32'h0, if32.out_pc}; a.fmt = if32.out_fmt;
          a.imm = {32'h0, if32.out_imm}; a.illegal = if32.out_illegal;
          check("out32_entry", a, e);
        end
      end
      if (if64.out_valid && if64.out_ready) begin
        check("out64_expected", q64.size() != 0, 1'b1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          a.instr = if64.out_instr; a.pc = if64.out_pc; a.fmt = if64.out_fmt;
          a.imm = if64.out_imm; a.illegal = if64.out_illegal;
          check("out64_entry", a, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    //            instr          fmt32  imm32          il  fmt64  imm64                   il
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h00000000, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b1};
    vecs[3]  = '{32'h800002B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0};
    vecs[4]  = '{32'h300FD0F3, CSR_FMT, CSR_IMM,   1'b0, CSR_FMT, {32'h0, CSR_IMM},  1'b0};
    vecs[5]  = '{32'hFE20AC23, 3'd2, 32'hFFFFFFF8, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[6]  = '{32'h8000006F, 3'd5, 32'hFFF00000, 1'b0, 3'd5, 64'hFFFFFFFFFFF00000, 1'b0};
    vecs[7]  = '{32'h001000EF, 3'd5, 32'h00000800, 1'b0, 3'd5, 64'h800,              1'b0};
    vecs[8]  = '{32'h002081B3, 3'd0, 32'h00000000, 1'b0, 3'd0, 64'h0,                1'b0};
    vecs[9]  = '{32'hFFF0009B, 3'd0, 32'h00000000, 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[10] = '{32'h002081BB, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b0};
    vecs[11] = '{32'h00412083, 3'd1, 32'h00000004, 1'b0, 3'd1, 64'h4,                1'b0};
    vecs[12] = '{32'h12345097, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h12345000,         1'b0};
    vecs[13] = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b1};

    rst32 = 1'b1; rst64 = 1'b1;
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_instr = '0; if32.in_pc = '0; if32.out_ready = 1'b0;
    if64.flush = 1'b0; if64.in_valid = 1'b0; if64.in_instr = '0; if64.in_pc = '0; if64.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst32_outputs", {if32.out_valid, if32.in_ready, if32.out_instr, if32.out_pc,
                            if32.out_fmt, if32.out_imm, if32.out_illegal}, '0);
    check("rst64_outputs", {if64.out_valid, if64.in_ready, if64.out_instr, if64.out_pc,
                            if64.out_fmt, if64.out_imm, if64.out_illegal}, '0);
    @(posedge clk); #1;
    rst32 = 1'b0; rst64 = 1'b0;

    // Streaming with simultaneous push/pop on the 32-bit instance.
    if32.out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) push32(i, 32'h1000 + 32'(i * 4));
    drain32();

    // Backpressure: third push must wait until the full queue pops.
    if32.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) push32(i + 5, 32'h2000 + 32'(i * 4));
      end
      begin
        repeat (4) @(negedge clk);
        check("full_hold_ready_valid", {if32.in_ready, if32.out_valid}, 2'b01);
        @(posedge clk); #1;
        if32.out_ready = 1'b1;
      end
    join
    drain32();

    // Flush with a full queue and a concurrent push.
    if32.out_ready = 1'b0;
    push32(0, 32'h3000);
    push32(1, 32'h3004);
    if32.in_valid = 1'b1; if32.in_instr = vecs[2].instr; if32.in_pc = 32'h3008; if32.flush = 1'b1;
    @(negedge clk);
    q32.delete();
    @(posedge clk); #1;
    if32.flush = 1'b0; if32.in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_ready", {if32.out_valid, if32.in_ready}, 2'b01);
    check("flush_data_zero", {if32.out_instr, if32.out_pc, if32.out_fmt, if32.out_imm, if32.out_illegal}, '0);
    @(posedge clk); #1;
    if32.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Reset mid-stream discards queued entries.
    if32.out_ready = 1'b0;
    push32(3, 32'h4000);
    push32(4, 32'h4004);
    rst32 = 1'b1;
    @(negedge clk);
    check("midrst_quiet", {if32.out_valid, if32.in_ready}, 2'b00);
    q32.delete();
    @(posedge clk); #1;
    rst32 = 1'b0;
    @(negedge clk);
    check("midrst_after", {if32.out_valid, if32.in_ready}, 2'b01);
    @(posedge clk); #1;
    if32.out_ready = 1'b1;
    push32(5, 32'h4008);
    drain32();

    // 64-bit instance: full table, then fill DEPTH=4.
    if64.out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) push64(i, 64'h8000_0000_0000_1000 + 64'(i * 4));
    drain64();
    if64.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push64(i + 9, 64'h5000 + 64'(i * 4));
    @(negedge clk);
    check("full64_ready_valid", {if64.in_ready, if64.out_valid}, 2'b01);
    @(posedge clk); #1;
    if64.out_ready = 1'b1;
    drain64();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, 2, output queue entries; SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  discards all queued and incoming entries.
REQ-006 in_valid  in  1  / in_ready  out  1  input handshake; transfer SHALL occur when both are high.
REQ-007 in_instr  in  32  raw instruction; in_pc  in  XLEN  its PC.
REQ-008 out_valid  out  1  / out_ready  in  1  output handshake; pop SHALL occur when both are high.
REQ-009 out_instr  out  32, out_pc  out  XLEN: carried through unchanged.
REQ-010 out_fmt  out  3  format code; out_imm  out  XLEN  extended immediate; out_illegal  out  1  unknown opcode.

Function
REQ-011 Format SHALL be decoded from instr[6:0] only: 0110111/0010111->U; 1101111->J; 1100111, 0000011, 0010011, 1110011->I; 0100011->S; 1100011->B; 0110011->R.
REQ-012 With XLEN=64, 0011011->I and 0111011->R; with XLEN=32 both SHALL be illegal.
REQ-013 Any other opcode SHALL give out_illegal=1, out_fmt=R, out_imm=0.
REQ-014 Immediates: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; all SHALL be sign-extended to XLEN.
REQ-015 U immediate SHALL be {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64; R immediate SHALL be 0.
REQ-016 Decode SHALL happen at enqueue; the queue stores instr, pc, fmt, imm, illegal.
REQ-017 Latency: an entry accepted in cycle N SHALL appear with out_valid=1 in cycle N+1 at the earliest; there SHALL be no combinational in->out path.
REQ-018 in_ready SHALL equal (count < DEPTH) and not rst; when full, no push SHALL occur even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop when not full or empty SHALL leave count unchanged and preserve FIFO order.
REQ-020 out_valid SHALL equal (count != 0); out_instr, out_pc, out_fmt, out_imm and out_illegal SHALL be 0 while out_valid=0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 flush high in cycle N SHALL make count=0 in N+1; a same-cycle push and pop SHALL both be discarded, and flush SHALL take priority over both.

Reset
REQ-023 While rst is high: count=0, pointers=0, out_valid=0, in_ready=0, all data outputs 0.
REQ-024 rst asserted mid-stream SHALL discard all entries; queue storage SHALL not need clearing.

Configuration
REQ-025 Macro IMM_ZICSR_EN defined: SYSTEM opcode with instr[14]=1 SHALL give fmt Z (6) and imm = zero-extended instr[19:15].
REQ-026 IMM_ZICSR_EN undefined: those instructions SHALL decode as I-type; code 6 SHALL never be emitted.

Structure
REQ-027 Package imm_pkg SHALL hold the format codes R=0, I=1, S=2, B=3, U=4, J=5, Z=6 and the opcode constants.
REQ-028 Combinational sub-module imm_decode (instr -> fmt, imm, illegal; XLEN parameter) SHALL be instantiated once on the enqueue path.

Verification
REQ-029 XLEN=32, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, fmt=I, imm=0xFFFFFFFF.
REQ-030 Push 0xFE000EE3 (beq -4) -> fmt=B, imm=0xFFFFFFFC; push 0x00000000 -> illegal=1, imm=0.
REQ-031 XLEN=64, push 0x800002B7 (lui x5,0x80000) -> fmt=U, imm=0xFFFFFFFF80000000.
REQ-032 DEPTH=2, out_ready=0, push 3 entries -> in_ready=0 after 2, third held; raise out_ready -> 3 entries emerge in order.
REQ-033 Full queue, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emerges.
REQ-034 Push 0x300FD0F3 (csrrwi x1,mstatus,31) -> with IMM_ZICSR_EN fmt=Z, imm=0x1F; without it fmt=I, imm=0x300.
